// File: rtl/securepuf_s00_axi.sv
// AXI4 burst slave front-end of the securePUF IP.
// Serves one burst at a time out of a 64 x 32-bit register file.
module securepuf_s00_axi #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [7:0]                    s00_axi_awlen,
    input  logic [2:0]                    s00_axi_awsize,
    input  logic [1:0]                    s00_axi_awburst,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                          s00_axi_wlast,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_bid,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [7:0]                    s00_axi_arlen,
    input  logic [2:0]                    s00_axi_arsize,
    input  logic [1:0]                    s00_axi_arburst,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rlast,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready
);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NB    = DW / 8;
    localparam int WORDS = 2 ** (AW - 2);

    typedef enum logic [2:0] {
        IDLE, WADDR, WDATA, WRESP, RADDR, RDATA
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [C_S_AXI_ID_WIDTH-1:0] t_id;
    logic [AW-1:0]               t_addr;
    logic [7:0]                  t_len;
    logic [2:0]                  t_size;
    logic [1:0]                  t_burst;
    logic                        t_err;
    logic [7:0]                  cnt;
    logic [1:0]                  bresp_q;
    logic [DW-1:0]               rdata_q;
    logic [DW-1:0]               mem [WORDS];
    logic [AW-1:0]               nxt_addr;
    logic                        last_beat;

    function automatic logic bad(input logic [7:0] len,
                                 input logic [2:0] size,
                                 input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || (size > 3'd2) ||
               ((burst == 2'b10) && !wrap_ok);
    endfunction

    // WRAP keeps the upper bits of the (len+1)*step block fixed
    function automatic logic [AW-1:0] adv(input logic [AW-1:0] a,
                                          input logic [7:0]    len,
                                          input logic [2:0]    size,
                                          input logic [1:0]    burst);
        logic [AW-1:0] step;
        logic [AW-1:0] mask;
        logic [15:0]   blk;
        step = AW'(1) << size;
        blk  = (16'(len) + 16'd1) << size;
        mask = AW'(blk - 16'd1);
        unique case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    assign nxt_addr  = adv(t_addr, t_len, t_size, t_burst);
    assign last_beat = (cnt == t_len);

    assign s00_axi_awready = (state == WADDR);
    assign s00_axi_wready  = (state == WDATA);
    assign s00_axi_bvalid  = (state == WRESP);
    assign s00_axi_arready = (state == RADDR);
    assign s00_axi_rvalid  = (state == RDATA);
    assign s00_axi_bid     = t_id;
    assign s00_axi_rid     = t_id;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = (state == RDATA && t_err) ? 2'b10 : 2'b00;
    assign s00_axi_rlast   = (state == RDATA) && last_beat;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (s00_axi_awvalid) begin
                    state_nxt = WADDR;
                end else if (s00_axi_arvalid) begin
                    state_nxt = RADDR;
                end
            end
            WADDR: if (s00_axi_awvalid) state_nxt = WDATA;
            WDATA: if (s00_axi_wvalid && s00_axi_wlast) state_nxt = WRESP;
            WRESP: if (s00_axi_bready) state_nxt = IDLE;
            RADDR: if (s00_axi_arvalid) state_nxt = RDATA;
            RDATA: if (s00_axi_rready && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            t_id    <= '0;
            t_addr  <= '0;
            t_len   <= '0;
            t_size  <= '0;
            t_burst <= '0;
            t_err   <= 1'b0;
            cnt     <= '0;
            bresp_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                WADDR: if (s00_axi_awvalid) begin
                    t_id    <= s00_axi_awid;
                    t_addr  <= s00_axi_awaddr;
                    t_len   <= s00_axi_awlen;
                    t_size  <= s00_axi_awsize;
                    t_burst <= s00_axi_awburst;
                    t_err   <= bad(s00_axi_awlen, s00_axi_awsize,
                                   s00_axi_awburst);
                    cnt     <= '0;
                end
                WDATA: if (s00_axi_wvalid) begin
                    if (!t_err) begin
                        for (int b = 0; b < NB; b++) begin
                            if (s00_axi_wstrb[b]) begin
                                mem[t_addr[AW-1:2]][8*b +: 8] <=
                                    s00_axi_wdata[8*b +: 8];
                            end
                        end
                    end
                    t_addr <= nxt_addr;
                    cnt    <= cnt + 8'd1;
                    if (s00_axi_wlast) begin
                        bresp_q <= (t_err || !last_beat) ? 2'b10 : 2'b00;
                    end
                end
                RADDR: if (s00_axi_arvalid) begin
                    t_id    <= s00_axi_arid;
                    t_addr  <= s00_axi_araddr;
                    t_len   <= s00_axi_arlen;
                    t_size  <= s00_axi_arsize;
                    t_burst <= s00_axi_arburst;
                    t_err   <= bad(s00_axi_arlen, s00_axi_arsize,
                                   s00_axi_arburst);
                    cnt     <= '0;
                    rdata_q <= bad(s00_axi_arlen, s00_axi_arsize,
                                   s00_axi_arburst) ? '0 :
                               mem[s00_axi_araddr[AW-1:2]];
                end
                RDATA: if (s00_axi_rready && !last_beat) begin
                    t_addr  <= nxt_addr;
                    cnt     <= cnt + 8'd1;
                    rdata_q <= t_err ? '0 : mem[nxt_addr[AW-1:2]];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/securepuf_s00_axi.md
# securepuf_s00_axi

AXI4 (full) slave front-end of the securePUF IP: terminates burst write and read transactions from the PS/interconnect (the AXI VIP master in simulation) and backs them with a 64 × 32-bit register file. That register file holds challenge, control and response words for the PUF core. It sits directly downstream of the AXI master and is the only path by which software reaches PUF state. One transaction is in service at a time; reads and writes are arbitrated in IDLE.

## Interface
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
- C_S_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 8, byte address width; 256 B space = 64 words

Ports:
- s00_axi_aclk  in  1  clock, all logic rising-edge
- s00_axi_aresetn  in  1  asynchronous, active-low reset (assert async, deassert sync to clock externally)
- s00_axi_awid / awaddr / awlen / awsize / awburst  in  ID / ADDR / 8 / 3 / 2  write address
- s00_axi_awvalid in 1; s00_axi_awready out 1
- s00_axi_wdata  in  32; s00_axi_wstrb  in  4; s00_axi_wlast  in  1; s00_axi_wvalid in 1; s00_axi_wready out 1
- s00_axi_bid  out  ID; s00_axi_bresp  out  2; s00_axi_bvalid out 1; s00_axi_bready in 1
- s00_axi_arid / araddr / arlen / arsize / arburst  in  ID / ADDR / 8 / 3 / 2  read address
- s00_axi_arvalid in 1; s00_axi_arready out 1
- s00_axi_rid  out  ID; s00_axi_rdata  out  32; s00_axi_rresp  out  2; s00_axi_rlast out 1; s00_axi_rvalid out 1; s00_axi_rready in 1
- LOCK/CACHE/PROT/QOS/REGION/USER are not ports; the wrapper leaves them unconnected.

## Operation
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE: awvalid=1 → WADDR (write wins over a simultaneous arvalid). Otherwise arvalid=1 → RADDR.
- WADDR: awready=1 for exactly one cycle; latch id/addr/len/size/burst; beat counter := 0 → WDATA.
- WDATA: wready=1. Each wvalid&wready beat writes mem[addr[7:2]] byte-wise per wstrb, then advances addr and the counter.
- On the wlast beat: wready=0, bvalid=1, bid=latched id → WRESP.
- WRESP: hold bvalid/bresp/bid until bready; on handshake → IDLE.
- RADDR: arready=1 for one cycle; latch fields → RDATA. rdata for beat 0 is registered from mem.
- RDATA: rvalid=1; rlast=1 when counter==arlen. rdata/rresp/rlast/rid are held stable while rready=0. On a handshake, advance addr; after the last beat rvalid=0 → IDLE.
- Address update per beat, step = 1<<size:
  - FIXED (00): addr unchanged.
  - INCR (01): addr += step, modulo 2^ADDR.
  - WRAP (10): addr += step, wrapped within the (len+1)*step aligned block.
- SLVERR (2'b10) conditions: burst==11, size>2, or WRAP with len ∉ {1,3,7,15}. Writes of an erroneous burst are suppressed; reads return rdata=0 with rresp=SLVERR on every beat.
- Write beat count ≠ awlen+1:
  - Data is still committed.
  - Termination is on wlast; excess beats are not possible because wready drops at wlast.
  - bresp=SLVERR.
- All other responses: OKAY (00).
- Narrow transfers: the write lane comes from wstrb; a read returns the full aligned word.

## Timing
- Reset (aresetn=0, immediate): state IDLE; all ready/valid outputs 0; bresp/rresp/rdata/bid/rid/rlast 0; memory cleared to 0. A reset mid-burst abandons the transaction with no response.
- AW/AR acceptance: awvalid sampled in IDLE at edge N → awready=1 in cycle N+1 → handshake at edge N+2.
- Writes: wready is high from the first WDATA cycle, giving one beat per cycle under continuous wvalid. bvalid is asserted the cycle after the wlast handshake.
- Reads: the first rvalid comes 1 cycle after the AR handshake; one beat per cycle with rready=1.
- Back-to-back: the next IDLE decision is made the cycle after B or the last R handshake.
- 8-beat INCR write with no stalls: AW handshake + 8 W cycles + B ≈ 12 cycles.

## Test plan
- INCR write, id 0, addr 0, len 7, size 2, data 1..8, wstrb F → bresp 00. Then INCR read of the same burst → rdata 1..8, rresp 00, rlast only on beat 8.
- WRAP write at 0x18, len 3, data A,B,C,D → mem words 6,7,4,5 = A,B,C,D. The matching WRAP read returns A,B,C,D in order.
- FIXED write at 0x10, len 3, data 1..4 → word 4 = 4. Byte write wstrb=0010 of 0xAABBCCDD to 0x20 → word 8 = 0x0000CC00.
- awvalid and arvalid asserted in the same cycle → write served first with bresp 00, then the read returns the newly written data. rready toggled 1/0 during the read → every rdata is held stable while stalled and no beat is lost or duplicated.
- awburst=11 or arlen=2 with WRAP → SLVERR. The write leaves memory unchanged; the read returns 0 on every beat.
- aresetn pulsed low after beat 3 of an 8-beat write → wready/bvalid drop immediately and memory reads back 0. A fresh INCR write/read after reset passes.
